// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: NCH-channel programmable clock divider fed by one shared, glitch-free config port.
// Optional CLK_DIV_CTRL_SYNC_RESTART_EN: every apply restarts and phase-aligns all running channels.
module clk_div_ctrl #(
  parameter int NCH   = 3,
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [1:0]       i_cfg_ch,
  input  logic [WIDTH-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_done,
  output logic             o_cfg_err,
  output logic [NCH-1:0]   o_tick,
  output logic [NCH-1:0]   o_clk
);
`ifdef CLK_DIV_CTRL_SYNC_RESTART_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  logic [1:0]       pend_ch;
  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] div [NCH];
  logic [WIDTH-1:0] cnt [NCH];
  logic [NCH-1:0]   hit, run, term, app;
  logic             bad, any_app;
  always_comb begin
    hit = '0;
    run = '0;
    term = '0;
    app = '0;
    for (int c = 0; c < NCH; c++) begin
      hit[c]  = !o_cfg_ready && pend_ch == 2'(c);
      run[c]  = div[c] != '0;
      term[c] = i_en && run[c] && cnt[c] == '0;
      app[c]  = hit[c] && (!run[c] || term[c]);
    end
    bad     = !o_cfg_ready && !(|hit);
    any_app = |app;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cfg_ready <= 1'b1;
      o_cfg_done  <= 1'b0;
      o_cfg_err   <= 1'b0;
      pend_ch     <= '0;
      pend_div    <= '0;
    end else begin
      o_cfg_done <= any_app;
      o_cfg_err  <= bad;
      if (i_cfg_valid && o_cfg_ready) begin
        o_cfg_ready <= 1'b0;
        pend_ch     <= i_cfg_ch;
        pend_div    <= i_cfg_div;
      end else if (any_app || bad) begin
        o_cfg_ready <= 1'b1;
      end
    end
  end
  // A running target only swaps divisors on its own terminal count, so o_clk never glitches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tick <= '0;
      o_clk  <= '0;
      for (int c = 0; c < NCH; c++) begin
        div[c] <= '0;
        cnt[c] <= '0;
      end
    end else begin
      o_tick <= term;
      for (int c = 0; c < NCH; c++) begin
        if (app[c]) begin
          div[c]   <= pend_div;
          cnt[c]   <= pend_div == '0 ? '0 : pend_div - 1'b1;
          o_clk[c] <= !SYNC && run[c] && pend_div != '0 && !o_clk[c];
        end else if (SYNC && any_app && run[c]) begin
          cnt[c]   <= div[c] - 1'b1;
          o_clk[c] <= 1'b0;
        end else if (term[c]) begin
          cnt[c]   <= div[c] - 1'b1;
          o_clk[c] <= !o_clk[c];
        end else if (i_en && run[c]) begin
          cnt[c] <= cnt[c] - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench; a phase-accumulating reference model queues expected outputs per edge.
module tb_clk_div_ctrl;
  localparam int NCH = 3;
  localparam int W   = 16;
`ifdef CLK_DIV_CTRL_SYNC_RESTART_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  logic           clk = 1'b0, rst = 1'b1, en = 1'b0, v = 1'b0;
  logic [1:0]     ch = '0;
  logic [W-1:0]   dv = '0;
  logic           rdy, done, err;
  logic [NCH-1:0] tick, ck;
  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] ck;
    logic           rdy;
    logic           done;
    logic           err;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;
  int md[NCH], ph[NCH];
  bit lvl[NCH];
  bit has, was, merr;
  int pch, pdv, app_ch;
  bit [NCH-1:0] t;
  exp_t e, m;

  clk_div_ctrl #(.NCH(NCH), .WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_cfg_valid(v), .i_cfg_ch(ch), .i_cfg_div(dv),
    .o_cfg_ready(rdy), .o_cfg_done(done), .o_cfg_err(err), .o_tick(tick), .o_clk(ck)
  );

  always #5 clk = ~clk;

  // Reference model: each channel tracks its phase within the current period (counting up).
  always @(posedge clk) begin
    cyc++;
    e = '0;
    if (rst) begin
      has = 0;
      for (int i = 0; i < NCH; i++) begin
        md[i] = 0;
        ph[i] = 0;
        lvl[i] = 0;
      end
      e.rdy = 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) t[i] = en && md[i] != 0 && ph[i] == md[i] - 1;
      was = has;
      app_ch = -1;
      merr = 0;
      if (has) begin
        if (pch >= NCH) begin
          merr = 1;
          has = 0;
        end else if (md[pch] == 0 || t[pch]) begin
          app_ch = pch;
          has = 0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (i == app_ch) begin
          if (md[i] != 0) lvl[i] = (pdv != 0 && !SYNC) ? !lvl[i] : 1'b0;
          md[i] = pdv;
          ph[i] = 0;
        end else if (SYNC && app_ch >= 0 && md[i] != 0) begin
          ph[i] = 0;
          lvl[i] = 0;
        end else if (t[i]) begin
          ph[i] = 0;
          lvl[i] = !lvl[i];
        end else if (en && md[i] != 0) begin
          ph[i]++;
        end
      end
      if (!was && v) begin
        has = 1;
        pch = int'(ch);
        pdv = int'(dv);
      end
      e.tick = t;
      for (int i = 0; i < NCH; i++) e.ck[i] = lvl[i];
      e.rdy  = !has;
      e.done = app_ch >= 0;
      e.err  = merr;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      total++;
      if ({tick, ck} !== {m.tick, m.ck}) begin
        bad++;
        $display("FAIL chan cyc=%0d got tick=%b clk=%b, expected tick=%b clk=%b", cyc, tick, ck, m.tick, m.ck);
      end
      total++;
      if ({rdy, done, err} !== {m.rdy, m.done, m.err}) begin
        bad++;
        $display("FAIL ctrl cyc=%0d got rdy/done/err=%b%b%b, expected %b%b%b", cyc, rdy, done, err, m.rdy, m.done, m.err);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg(input int c, input int d);
    bit acc;
    int n = 0;
    v = 1'b1;
    ch = c[1:0];
    dv = d[W-1:0];
    do begin
      acc = rdy;
      @(posedge clk);
      #2;
      n++;
    end while (!acc && n < 60);
    v = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL cfg_accept ch=%0d got ready stuck low, expected accept within 60 cycles", c);
    end
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    en = 1'b1;
    cfg(0, 4);
    step(20);
    step(1);
    cfg(0, 2);
    step(10);
    cfg(3, 5);
    step(4);
    cfg(1, 1);
    step(6);
    en = 1'b0;
    step(10);
    en = 1'b1;
    step(6);
    cfg(2, 3);
    step(8);
    cfg(2, 0);
    step(10);
    cfg(0, 6);
    step(8);
    cfg(1, 4);
    step(20);
    cfg(1, 3);
    step(20);
    repeat (800) begin
      v  = $urandom_range(0, 3) == 0;
      ch = 2'($urandom_range(0, 3));
      dv = W'($urandom_range(0, 6));
      en = $urandom_range(0, 7) != 0;
      step(1);
    end
    v = 1'b0;
    en = 1'b1;
    cfg(0, 7);
    step(2);
    cfg(0, 3);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({tick, ck, rdy, done, err} !== {{NCH{1'b0}}, {NCH{1'b0}}, 3'b100}) begin
      bad++;
      $display("FAIL async_reset got tick=%b clk=%b rdy/done/err=%b%b%b, expected all zero with rdy=1", tick, ck, rdy, done, err);
    end
    step(2);
    rst = 1'b0;
    cfg(0, 2);
    cfg(2, 5);
    step(15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Multi-channel programmable clock-divider controller: one shared configuration port loads divisors into NCH independent divider channels. Each channel emits a one-cycle tick and a divided square wave. A new divisor is applied only at the channel's period boundary, so outputs never glitch. The block sits between the host/command logic and the motor-step and sensor-sampling timing consumers, and replaces fixed-ratio dividers.

## Interface
- NCH, 3, number of divider channels (1..4)
- WIDTH, 16, divisor width in bits
- i_clk  input  1  system clock; all state is updated on the rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_en  input  1  global run; counters freeze while low
- i_cfg_valid  input  1  configuration request
- i_cfg_ch  input  2  target channel index
- i_cfg_div  input  WIDTH  divisor; 0 = channel disabled
- o_cfg_ready  output  1  configuration slot empty; request accepted when valid & ready
- o_cfg_done  output  1  one-cycle pulse: pending divisor has taken effect
- o_cfg_err  output  1  one-cycle pulse: accepted request had i_cfg_ch >= NCH
- o_tick  output  NCH  per-channel one-cycle pulse at terminal count
- o_clk  output  NCH  per-channel divided clock; toggles on each tick

## Operation
- Per-channel state: div[WIDTH], cnt[WIDTH], o_clk bit.
- There is one global pending slot holding a channel and a divisor. o_cfg_ready = slot empty; it is registered and does not depend on inputs.
- Accept (valid & ready at an edge): the slot is loaded and ready drops on that same edge. An invalid channel is discarded: o_cfg_err pulses on the next edge and ready rises on that same edge.
- Running channel (div != 0), i_en=1: cnt decrements each cycle. When cnt==0:
  - o_tick pulses.
  - o_clk toggles.
  - cnt reloads with (new or current div) - 1.
- Apply to a running channel: happens only at that channel's terminal count. div ← pending value, o_cfg_done pulses, ready rises.
- Apply to a disabled channel: happens on the edge after accept, regardless of i_en. cnt ← div-1, o_clk stays 0, done pulses.
- Writing 0 to a running channel: the final terminal count still ticks. On that edge o_clk is forced to 0 (not toggled) and cnt is held at 0. Afterwards there are no ticks and o_clk stays low.
- Writing 0 to a disabled channel: done pulses on the next edge; no other effect.
- div=1: tick every cycle; o_clk = i_clk/2.
- i_en=0: cnt, o_clk and div hold; o_tick=0. Accepts still occur. A pending update to a running channel waits for the next terminal count after i_en returns.

## Timing
- Reset values: div=0 and cnt=0 for all channels; o_tick=0, o_clk=0, o_cfg_ready=1, o_cfg_done=0, o_cfg_err=0. Reset clears the pending slot.
- Reset mid-operation clears all state asynchronously. The first accept is possible on the first edge after release.
- All outputs are registered.
- Running divisor D: o_tick period is D cycles; o_clk period is 2D cycles at 50% duty.
- Enabling a disabled channel with D: o_cfg_done is high in the cycle after the accept edge. The first o_tick comes D cycles after o_cfg_done.
- Retargeting a running channel: done is coincident with that channel's tick. The following tick comes D_new cycles later.
- Simultaneous events:
  - A tick and an apply on the same edge produce both pulses.
  - A new request can be accepted on the edge after done (not the same edge).

## Configuration
- CLK_DIV_CTRL_SYNC_RESTART_EN defined:
  - Any apply restarts every running channel.
  - On the apply edge, all running channels reload cnt ← div-1 and clear o_clk to 0. This includes the target channel, which still emits its tick.
  - Non-target channels tick only if they were at terminal count on that edge.
  - Result: all outputs are phase-aligned after every reconfiguration.
- Not defined: only the target channel is affected; other channels continue undisturbed.

## Test plan
- Reset, then write ch0 div=4 with i_en=1 -> done 1 cycle after accept; first o_tick[0] 4 cycles later; tick every 4 cycles; o_clk[0] period 8 cycles.
- ch0 running at 4; write div=2 mid-period -> o_cfg_ready low until ch0's next tick; done coincident with that tick; next ticks every 2 cycles.
- Write ch3 (NCH=3) div=5 -> o_cfg_err pulse 1 cycle after accept; no channel changes; ready back high.
- ch1 div=1 -> o_tick[1] constantly high, o_clk[1] toggles every cycle. Drop i_en for 10 cycles -> ticks stop, o_clk[1] holds; restore -> resumes.
- ch2 running at 3; write 0 -> one final tick; o_clk[2] goes to 0 and stays there; no further ticks.
- Assert i_rst while an update is pending -> all outputs at reset values immediately; ready=1. With SYNC_RESTART: ch0=6 and ch1=4 running, reconfigure ch1 -> both o_clk low on the apply edge, then run aligned.
